// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule FSM encoding and the small-sigma functions
// used by both the message schedule and the round datapath.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;
    localparam int ROUNDS    = 64;

    localparam logic [3:0] LD_LAST = 4'd15;
    localparam logic [5:0] T_LAST  = 6'd63;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Stream bundle between the message memory, the schedule block and the round datapath.
interface sha256_msg_schedule_if;

    logic                blk_start;
    sha256_pkg::word_t   word_in;
    logic                word_in_valid;
    logic                word_in_ready;
    sha256_pkg::word_t   w_out;
    logic                w_valid;
    logic                w_ready;
    logic [5:0]          round_idx;
    logic                busy;
    logic                done;

    modport master (
        output blk_start, word_in, word_in_valid, w_ready,
        input  word_in_ready, w_out, w_valid, round_idx, busy, done
    );

    modport slave (
        input  blk_start, word_in, word_in_valid, w_ready,
        output word_in_ready, w_out, w_valid, round_idx, busy, done
    );

endinterface

// File: rtl/sha256_w_expand.sv
// Combinational schedule recurrence: the word that enters the top of the window
// when the oldest word is consumed.
module sha256_w_expand
    import sha256_pkg::*;
(
    input  word_t win0,
    input  word_t win1,
    input  word_t win9,
    input  word_t win14,
    output word_t win15_next
);

    assign win15_next = small_sigma1(win14) + win9 + small_sigma0(win1) + win0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then streams W[0..63] out of a
// 16-word shift window with the round index alongside.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    sha256_msg_schedule_if.slave bus
);

    state_t     state_r;
    state_t     state_s;
    word_t      win_r [BLK_WORDS];
    logic [3:0] ld_cnt_r;
    logic [5:0] t_r;
    word_t      win15_s;
    logic       load_acc_s;
    logic       emit_acc_s;
    logic       word_in_ready_s;
    logic       w_valid_s;
    logic       busy_s;
    logic       done_s;

    sha256_w_expand u_expand (
        .win0       (win_r[0]),
        .win1       (win_r[1]),
        .win9       (win_r[9]),
        .win14      (win_r[14]),
        .win15_next (win15_s)
    );

    // Handshake and status flags decoded from the state register
    always_comb begin
        word_in_ready_s = 1'b0;
        w_valid_s       = 1'b0;
        busy_s          = 1'b0;
        done_s          = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            LOAD: begin
                word_in_ready_s = 1'b1;
                busy_s          = 1'b1;
            end
            EXPAND: begin
                w_valid_s = 1'b1;
                busy_s    = 1'b1;
            end
            DONE: begin
                done_s = 1'b1;
                busy_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign load_acc_s = word_in_ready_s & bus.word_in_valid;
    assign emit_acc_s = w_valid_s & bus.w_ready;

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.blk_start) state_s = LOAD;
                else               state_s = IDLE;
            end
            LOAD: begin
                if (load_acc_s && (ld_cnt_r == LD_LAST)) state_s = EXPAND;
                else                                     state_s = LOAD;
            end
            EXPAND: begin
                if (emit_acc_s && (t_r == T_LAST)) state_s = DONE;
                else                               state_s = EXPAND;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Window load, shift-and-expand, and the load/round counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BLK_WORDS; i++) win_r[i] <= 32'h0000_0000;
            ld_cnt_r <= 4'd0;
            t_r      <= 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.blk_start) ld_cnt_r <= 4'd0;
                end
                LOAD: begin
                    if (load_acc_s) begin
                        win_r[ld_cnt_r] <= bus.word_in;
                        ld_cnt_r        <= ld_cnt_r + 4'd1;
                    end
                end
                EXPAND: begin
                    // Expansion also runs past t=48; those words are never emitted
                    if (emit_acc_s) begin
                        for (int i = 0; i < BLK_WORDS - 1; i++) win_r[i] <= win_r[i+1];
                        win_r[BLK_WORDS-1] <= win15_s;
                        t_r                <= t_r + 6'd1;
                    end
                end
                default: begin
                    t_r <= t_r;
                end
            endcase
        end
    end

    assign bus.word_in_ready = word_in_ready_s;
    assign bus.w_valid       = w_valid_s;
    assign bus.w_out         = win_r[0];
    assign bus.round_idx     = t_r;
    assign bus.busy          = busy_s;
    assign bus.done          = done_s;

endmodule
